// File: rtl/mmc1_serial_writer.sv
// mmc1_serial_writer
//   Bus master that replays a parallel MMC1 register load as the CPU write
//   sequence the mapper expects: an optional $80 shift-reset write, then five
//   single-bit writes (LSB first) to $8000/$A000/$C000/$E000. Every write is
//   followed by GAP_CE ce ticks with cpu_write low.
//
// Parameters
//   GAP_CE     : ce ticks with cpu_write low between writes (>= 1)
//   FIFO_DEPTH : request FIFO depth (power of two, >= 2), FIFO build only
//
// Build option
//   MMC1_WR_FIFO_EN : when defined, requests queue in a FIFO_DEPTH-entry FIFO
//                     and req_ready = !full. When undefined, a single holding
//                     register is used and req_ready is low from accept to done.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   ce                : CPU M2 enable, the FSM only advances on ce
//   req_valid/ready   : request handshake (accept needs no ce)
//   req_reg/data/sync : target register, 5-bit value, shift-reset request
//   cpu_addr/dout     : write address / data towards the mapper
//   cpu_write         : write strobe, one ce period wide
//   busy              : request pending or in progress
//   done              : one-clk pulse when the final gap of a request completes
module mmc1_serial_writer #(
  parameter int GAP_CE     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_reg,
  input  logic [4:0]  req_data,
  input  logic        req_sync,
  output logic [15:0] cpu_addr,
  output logic [7:0]  cpu_dout,
  output logic        cpu_write,
  output logic        busy,
  output logic        done
);

  localparam int GW = (GAP_CE > 1) ? $clog2(GAP_CE) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_WR  = 3'd1,
    RST_GAP = 3'd2,
    BIT_WR  = 3'd3,
    BIT_GAP = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            done_q, done_d;

  // Current request source: head of the FIFO or the holding register. The
  // entry stays in place while it is being sent and is released on done.
  logic            src_valid;
  logic [1:0]      src_reg;
  logic [4:0]      src_data;
  logic            src_sync;
  logic            push;
  logic            pop;

  assign push = req_valid && req_ready;
  assign pop  = done_d;

`ifdef MMC1_WR_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;

  assign req_ready = (cnt_q != (AW+1)'(FIFO_DEPTH));
  assign src_valid = (cnt_q != '0);
  assign {src_sync, src_reg, src_data} = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      // Simultaneous push and pop leaves the count unchanged.
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {req_sync, req_reg, req_data};
  end
`else
  logic       hold_v_q;
  logic [1:0] hold_reg_q;
  logic [4:0] hold_data_q;
  logic       hold_sync_q;

  assign req_ready = !hold_v_q;
  assign src_valid = hold_v_q;
  assign src_reg   = hold_reg_q;
  assign src_data  = hold_data_q;
  assign src_sync  = hold_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v_q <= 1'b0;
    end else if (push) begin
      hold_v_q <= 1'b1;
    end else if (pop) begin
      hold_v_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      hold_reg_q  <= req_reg;
      hold_data_q <= req_data;
      hold_sync_q <= req_sync;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (src_valid) begin
            state_d = src_sync ? RST_WR : BIT_WR;
            bit_d   = '0;
            gap_d   = '0;
          end
        end
        RST_WR: begin
          state_d = RST_GAP;
          gap_d   = '0;
        end
        RST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = BIT_WR;
            bit_d   = '0;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        BIT_WR: begin
          state_d = BIT_GAP;
          gap_d   = '0;
        end
        BIT_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            if (bit_q == 3'd4) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              bit_d   = bit_q + 3'd1;
              state_d = BIT_WR;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode the registered state only, so the strobe can only move on
  // a ce edge and spans exactly one ce period.
  always_comb begin
    cpu_addr  = '0;
    cpu_dout  = '0;
    cpu_write = 1'b0;
    case (state_q)
      RST_WR: begin
        cpu_addr  = 16'h8000;
        cpu_dout  = 8'h80;
        cpu_write = 1'b1;
      end
      RST_GAP: begin
        cpu_addr = 16'h8000;
        cpu_dout = 8'h80;
      end
      BIT_WR: begin
        cpu_addr  = {1'b1, src_reg, 13'h0000};
        cpu_dout  = {7'b0, src_data[bit_q]};
        cpu_write = 1'b1;
      end
      BIT_GAP: begin
        cpu_addr = {1'b1, src_reg, 13'h0000};
        cpu_dout = {7'b0, src_data[bit_q]};
      end
      default: ;
    endcase
  end

  assign busy = src_valid || (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mmc1_serial_writer.sv
module tb_mmc1_serial_writer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ce, req_valid, req_valid2, req_sync;
  logic [1:0]  req_reg;
  logic [4:0]  req_data;

  logic        req_ready, cpu_write, busy, done;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        req_ready2, cpu_write2, busy2, done2;
  logic [15:0] cpu_addr2;
  logic [7:0]  cpu_dout2;

  mmc1_serial_writer #(.GAP_CE(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data), .req_sync(req_sync),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_write(cpu_write),
    .busy(busy), .done(done)
  );

  mmc1_serial_writer #(.GAP_CE(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_reg(req_reg), .req_data(req_data), .req_sync(req_sync),
    .cpu_addr(cpu_addr2), .cpu_dout(cpu_dout2), .cpu_write(cpu_write2),
    .busy(busy2), .done(done2)
  );

  int checks = 0;
  int failures = 0;

  // ce generation
  bit ce_en;
  int ce_div, ce_phase;

  // mapper model (fed by u_dut)
  logic [4:0] m_sr;
  int         m_n;
  logic [4:0] m_regs [4];

  // event logs
  int          tick;
  int          n_w;
  int          w_tick [32];
  logic [15:0] w_addr [32];
  logic [7:0]  w_dout [32];
  int          n_done, done_tick, n_done2;
  logic        ready_at_done;
  int          n_acc;
  logic        acc_saw_done;
  int          viol;
  logic        prev_w1, prev_w2;
  int          hi_runs[$];
  int          lo_runs[$];
  int          run2;
  logic        lvl2, seen_hi2;

  task automatic cyc();
    ce = ce_en && (ce_phase == 0);
    ce_phase = (ce_phase + 1) % ce_div;
    // what the mapper samples on this edge
    if (ce && cpu_write) begin
      if (cpu_dout[7]) begin
        m_sr = 5'd0;
        m_n  = 0;
      end else begin
        m_sr = {cpu_dout[0], m_sr[4:1]};
        m_n++;
        if (m_n == 5) begin
          m_regs[cpu_addr[14:13]] = m_sr;
          m_n = 0;
        end
      end
    end
    if (req_valid && req_ready) begin
      n_acc++;
      acc_saw_done = done;
    end
    @(posedge clk);
    #1;
    if (ce) begin
      tick++;
      if (cpu_write && prev_w1) viol++;
      if (cpu_write2 && prev_w2) viol++;
      prev_w1 = cpu_write;
      prev_w2 = cpu_write2;
      if (cpu_write && n_w < 32) begin
        w_tick[n_w] = tick;
        w_addr[n_w] = cpu_addr;
        w_dout[n_w] = cpu_dout;
        n_w++;
      end
    end
    if (done) begin
      n_done++;
      done_tick = tick;
      ready_at_done = req_ready;
    end
    if (done2) n_done2++;
    if (cpu_write2 == lvl2) begin
      run2++;
    end else begin
      if (lvl2) begin
        hi_runs.push_back(run2);
        seen_hi2 = 1'b1;
      end else if (seen_hi2) begin
        lo_runs.push_back(run2);
      end
      lvl2 = cpu_write2;
      run2 = 1;
    end
  endtask

  task automatic clear_log();
    tick = 0;
    n_w  = 0;
  endtask

  task automatic run_until_done(input int target, input int budget);
    for (int k = 0; k < budget && n_done < target; k++) cyc();
  endtask

  task automatic accept(input logic [1:0] r, input logic [4:0] d, input logic s);
    req_reg = r; req_data = d; req_sync = s; req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ce_en = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if ({busy, done, cpu_write} !== 3'b000) begin failures++; $display("FAIL reset_ctrl: got busy/done/write=%b want 000", {busy, done, cpu_write}); end
    checks++; if ({cpu_addr, cpu_dout} !== 24'h0) begin failures++; $display("FAIL reset_bus: got %h want 000000", {cpu_addr, cpu_dout}); end
    checks++; if ({req_ready2, busy2, cpu_write2, done2, cpu_addr2, cpu_dout2} !== {4'b1000, 24'h0}) begin
      failures++; $display("FAIL reset_dut2: got %h want 8000000", {req_ready2, busy2, cpu_write2, done2, cpu_addr2, cpu_dout2});
    end
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [4:0] d;
    int base;
    d = 5'b10110;
    base = n_done;
    accept(2'd3, d, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_on_accept: got %b want 1", busy); end
`ifndef MMC1_WR_FIFO_EN
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_on_accept: got %b want 0", req_ready); end
`endif
    clear_log();
    run_until_done(base + 1, 100);
    checks++; if (n_done !== base + 1) begin failures++; $display("FAIL basic_done_count: got %0d want %0d", n_done, base + 1); end
    checks++; if (n_w !== 5) begin failures++; $display("FAIL basic_write_count: got %0d want 5", n_w); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (w_tick[i] !== 2 * i + 1 || w_addr[i] !== 16'hE000 || w_dout[i] !== {7'b0, d[i]}) begin
        failures++;
        $display("FAIL basic_write%0d: got tick=%0d addr=%h data=%h want tick=%0d addr=e000 data=%h",
                 i, w_tick[i], w_addr[i], w_dout[i], 2 * i + 1, {7'b0, d[i]});
      end
    end
    checks++; if (done_tick !== 11) begin failures++; $display("FAIL basic_done_tick: got %0d want 11", done_tick); end
    checks++; if (ready_at_done !== 1'b1) begin failures++; $display("FAIL basic_ready_at_done: got %b want 1", ready_at_done); end
    checks++; if (m_regs[3] !== 5'b10110) begin failures++; $display("FAIL basic_prg_bank: got %b want 10110", m_regs[3]); end
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_sync();
    logic [4:0] d;
    int base;
    d = 5'b01100;
    base = n_done;
    accept(2'd0, d, 1'b1);
    clear_log();
    run_until_done(base + 1, 100);
    checks++; if (n_w !== 6) begin failures++; $display("FAIL sync_write_count: got %0d want 6", n_w); end
    checks++;
    if (w_tick[0] !== 1 || w_addr[0] !== 16'h8000 || w_dout[0] !== 8'h80) begin
      failures++; $display("FAIL sync_reset_write: got tick=%0d addr=%h data=%h want tick=1 addr=8000 data=80", w_tick[0], w_addr[0], w_dout[0]);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (w_tick[i+1] !== 2 * i + 3 || w_addr[i+1] !== 16'h8000 || w_dout[i+1] !== {7'b0, d[i]}) begin
        failures++;
        $display("FAIL sync_write%0d: got tick=%0d addr=%h data=%h want tick=%0d addr=8000 data=%h",
                 i, w_tick[i+1], w_addr[i+1], w_dout[i+1], 2 * i + 3, {7'b0, d[i]});
      end
    end
    checks++; if (done_tick !== 13) begin failures++; $display("FAIL sync_done_tick: got %0d want 13", done_tick); end
    checks++; if (m_regs[0] !== 5'b01100) begin failures++; $display("FAIL sync_control: got %b want 01100", m_regs[0]); end
  endtask

  task automatic test_gap();
    int base2;
    logic ok;
    hi_runs.delete(); lo_runs.delete();
    seen_hi2 = 1'b0; viol = 0;
    ce_div = 3; ce_phase = 0;
    base2 = n_done2;
    req_reg = 2'd2; req_data = 5'b01011; req_sync = 1'b1; req_valid2 = 1'b1;
    cyc();
    req_valid2 = 1'b0;
    for (int k = 0; k < 400 && n_done2 == base2; k++) cyc();
    checks++; if (n_done2 !== base2 + 1) begin failures++; $display("FAIL gap_done: got %0d want %0d", n_done2, base2 + 1); end
    checks++; if (hi_runs.size() !== 6) begin failures++; $display("FAIL gap_write_count: got %0d want 6", hi_runs.size()); end
    ok = 1'b1;
    foreach (hi_runs[i]) if (hi_runs[i] != 3) ok = 1'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL gap_high_len: got first=%0d want 3 clks each", hi_runs.size() > 0 ? hi_runs[0] : -1); end
    checks++; if (lo_runs.size() !== 5) begin failures++; $display("FAIL gap_low_count: got %0d want 5", lo_runs.size()); end
    ok = 1'b1;
    foreach (lo_runs[i]) if (lo_runs[i] != 6) ok = 1'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL gap_low_len: got first=%0d want 6 clks each", lo_runs.size() > 0 ? lo_runs[0] : -1); end
    checks++; if (viol !== 0) begin failures++; $display("FAIL gap_consecutive_writes: got %0d want 0", viol); end
    ce_div = 1; ce_phase = 0;
  endtask

  task automatic test_reset_mid();
    int base;
    accept(2'd2, 5'b11111, 1'b0);
    clear_log();
    for (int k = 0; k < 50 && n_w < 2; k++) cyc();
    checks++; if (n_w !== 2) begin failures++; $display("FAIL rstmid_reach: got %0d writes want 2", n_w); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if (cpu_write !== 1'b0) begin failures++; $display("FAIL rstmid_write: got %b want 0", cpu_write); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
    base = n_done;
    accept(2'd1, 5'b00011, 1'b1);
    run_until_done(base + 1, 100);
    checks++; if (n_done !== base + 1) begin failures++; $display("FAIL rstmid_done: got %0d want %0d", n_done, base + 1); end
    checks++; if (m_regs[1] !== 5'b00011) begin failures++; $display("FAIL rstmid_chr0: got %b want 00011", m_regs[1]); end
  endtask

`ifndef MMC1_WR_FIFO_EN
  task automatic test_holdoff();
    int base;
    base = n_done;
    accept(2'd3, 5'b01001, 1'b0);
    n_acc = 0; acc_saw_done = 1'b0;
    req_reg = 2'd2; req_data = 5'b10101; req_sync = 1'b1; req_valid = 1'b1;
    for (int k = 0; k < 100 && n_acc == 0; k++) cyc();
    req_valid = 1'b0;
    checks++; if (n_acc !== 1) begin failures++; $display("FAIL hold_accept: got %0d want 1", n_acc); end
    checks++; if (n_done !== base + 1) begin failures++; $display("FAIL hold_first_done: got %0d want %0d", n_done, base + 1); end
    checks++; if (acc_saw_done !== 1'b1) begin failures++; $display("FAIL hold_accept_on_done: got %b want 1", acc_saw_done); end
    run_until_done(base + 2, 100);
    checks++; if (n_done !== base + 2) begin failures++; $display("FAIL hold_second_done: got %0d want %0d", n_done, base + 2); end
    checks++; if (m_regs[3] !== 5'b01001) begin failures++; $display("FAIL hold_prg: got %b want 01001", m_regs[3]); end
    checks++; if (m_regs[2] !== 5'b10101) begin failures++; $display("FAIL hold_chr1: got %b want 10101", m_regs[2]); end
  endtask
`else
  task automatic test_fifo_full();
    int base;
    logic [1:0] rr [5];
    logic [4:0] dd [5];
    rr[0] = 2'd0; dd[0] = 5'b01010;
    rr[1] = 2'd1; dd[1] = 5'b00101;
    rr[2] = 2'd2; dd[2] = 5'b11000;
    rr[3] = 2'd3; dd[3] = 5'b00111;
    rr[4] = 2'd1; dd[4] = 5'b11110;
    base = n_done;
    ce_en = 1'b0;
    for (int i = 0; i < 4; i++) accept(rr[i], dd[i], (i == 0));
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL fifo_full_ready: got %b want 0", req_ready); end
    n_acc = 0; acc_saw_done = 1'b0;
    req_reg = rr[4]; req_data = dd[4]; req_sync = 1'b0; req_valid = 1'b1;
    ce_en = 1'b1;
    for (int k = 0; k < 100 && n_acc == 0; k++) cyc();
    req_valid = 1'b0;
    checks++; if (n_done !== base + 1) begin failures++; $display("FAIL fifo_fifth_wait: got %0d dones want %0d", n_done, base + 1); end
    checks++; if (acc_saw_done !== 1'b1) begin failures++; $display("FAIL fifo_accept_on_done: got %b want 1", acc_saw_done); end
    run_until_done(base + 5, 400);
    checks++; if (n_done !== base + 5) begin failures++; $display("FAIL fifo_done_count: got %0d want %0d", n_done, base + 5); end
    checks++;
    if ({m_regs[0], m_regs[1], m_regs[2], m_regs[3]} !== {5'b01010, 5'b11110, 5'b11000, 5'b00111}) begin
      failures++; $display("FAIL fifo_regs: got %b %b %b %b want 01010 11110 11000 00111", m_regs[0], m_regs[1], m_regs[2], m_regs[3]);
    end
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fifo_busy_after: got %b want 0", busy); end
  endtask
`endif

  initial begin
    reset = 1'b1; ce = 1'b0; ce_en = 1'b0; ce_div = 1; ce_phase = 0;
    req_valid = 1'b0; req_valid2 = 1'b0; req_reg = 2'd0; req_data = 5'd0; req_sync = 1'b0;
    m_sr = 5'd0; m_n = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 5'd0;
    tick = 0; n_w = 0; n_done = 0; done_tick = 0; n_done2 = 0; ready_at_done = 1'b0;
    n_acc = 0; acc_saw_done = 1'b0; viol = 0; prev_w1 = 1'b0; prev_w2 = 1'b0;
    run2 = 0; lvl2 = 1'b0; seen_hi2 = 1'b0;

    test_reset();
    test_basic();
    test_sync();
    test_gap();
    test_reset_mid();
`ifndef MMC1_WR_FIFO_EN
    test_holdoff();
`else
    test_fifo_full();
`endif
    checks++; if (viol !== 0) begin failures++; $display("FAIL no_consecutive_writes: got %0d want 0", viol); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
